// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                       |
// | Purpose  : Shared types, constants and helpers for the instruction fetch   |
// |            stage: queue entry layout, bubble instruction, PC increment.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fetch_pkg;

   // Datapath width of a queue entry. The fetch stage XLEN parameter must
   // match this value because the entry type is fixed at package level.
   localparam int FQ_XLEN = 32;

   // Bubble instruction: addi x0, x0, 0
   localparam logic [FQ_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // One fetch queue slot. 'filled' goes high once the in-order imem
   // response for this PC has been written into 'instr'.
   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] instr;
      logic               filled;
   } fq_entry_t;

   // Sequential PC; wraps silently at 2^FQ_XLEN.
   function automatic logic [FQ_XLEN-1:0] pc_plus4(input logic [FQ_XLEN-1:0] pc);
      return pc + FQ_XLEN'(4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_queue                                                     |
// | Purpose  : In-order circular buffer of outstanding fetches. Entries are    |
// |            allocated at the tail when a request is granted, filled in      |
// |            order as responses return, and popped from the head.           |
// | Ports    : i_clk, i_rst_n     clock, async active-low reset                |
// |            alloc, alloc_pc    allocate tail entry for a granted PC         |
// |            fill, fill_instr   write oldest unfilled entry                  |
// |            pop                retire head entry                            |
// |            clear              drop all entries (redirect)                  |
// |            head, head_valid   oldest entry and whether it exists           |
// |            alloc_cnt          entries allocated                            |
// |            unfilled_cnt       allocated entries still awaiting data        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               alloc,
   input  logic [FQ_XLEN-1:0] alloc_pc,
   input  logic               fill,
   input  logic [FQ_XLEN-1:0] fill_instr,
   input  logic               pop,
   input  logic               clear,
   output fq_entry_t          head,
   output logic               head_valid,
   output logic [CW-1:0]      alloc_cnt,
   output logic [CW-1:0]      unfilled_cnt
);

   localparam int PW = $clog2(DEPTH);

   fq_entry_t       r_mem [DEPTH];
   logic [PW-1:0]   r_head_ptr;
   logic [PW-1:0]   r_tail_ptr;
   logic [PW-1:0]   r_fill_ptr;
   logic [CW-1:0]   r_alloc_cnt;
   logic [CW-1:0]   r_unfilled_cnt;

   // Explicit wrap compare so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // The caller guarantees: no alloc when full, no fill without an unfilled
   // entry, no pop unless the head is filled. Under those rules the tail,
   // fill and head slots touched in one cycle are always distinct.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head_ptr     <= '0;
         r_tail_ptr     <= '0;
         r_fill_ptr     <= '0;
         r_alloc_cnt    <= '0;
         r_unfilled_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (clear) begin
         r_head_ptr     <= '0;
         r_tail_ptr     <= '0;
         r_fill_ptr     <= '0;
         r_alloc_cnt    <= '0;
         r_unfilled_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i].filled <= 1'b0;
         end
      end else begin
         if (alloc) begin
            r_mem[r_tail_ptr].pc     <= alloc_pc;
            r_mem[r_tail_ptr].filled <= 1'b0;
            r_tail_ptr               <= next_ptr(r_tail_ptr);
         end
         if (fill) begin
            r_mem[r_fill_ptr].instr  <= fill_instr;
            r_mem[r_fill_ptr].filled <= 1'b1;
            r_fill_ptr               <= next_ptr(r_fill_ptr);
         end
         if (pop) begin
            r_mem[r_head_ptr].filled <= 1'b0;
            r_head_ptr               <= next_ptr(r_head_ptr);
         end
         r_alloc_cnt    <= r_alloc_cnt + CW'(alloc) - CW'(pop);
         r_unfilled_cnt <= r_unfilled_cnt + CW'(alloc) - CW'(fill);
      end
   end

   assign head         = r_mem[r_head_ptr];
   assign head_valid   = (r_alloc_cnt != '0);
   assign alloc_cnt    = r_alloc_cnt;
   assign unfilled_cnt = r_unfilled_cnt;

endmodule
`default_nettype wire

// File: rtl/fetch_stage_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_stage_q                                                   |
// | Purpose  : IF stage of the 5-stage pipeline. Owns the PC, issues req/gnt   |
// |            fetches to a variable-latency imem, buffers them in an in-order |
// |            queue and drives the IF/ID register. Handles decode stall,      |
// |            decode flush and EX redirect with discard of in-flight data.    |
// | Ports    : i_clk, i_rst_n               clock, async active-low reset      |
// |            PCSrcE, PCTargetE            EX redirect and its target         |
// |            StallD, FlushD               IF/ID hold / clear-to-bubble       |
// |            o_imem_req, o_imem_addr      fetch request and address          |
// |            i_imem_gnt                   request accepted this cycle        |
// |            i_imem_rvalid, i_imem_rdata  in-order response                  |
// |            InstrD, PCD, PCPlus4D        IF/ID register contents            |
// |            ValidD                       IF/ID holds a real instruction     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_stage_q #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            StallD,
   input  logic            FlushD,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   import fetch_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);
   // Responses still owed after a redirect can exceed DEPTH once new
   // fetches are issued behind them, hence one extra bit.
   localparam int KW = CW + 1;

   logic [XLEN-1:0] r_pc;
   logic [KW-1:0]   r_kill_cnt;
   logic [KW-1:0]   w_kill_next;
   logic [XLEN-1:0] r_instr_d;
   logic [XLEN-1:0] r_pc_d;
   logic [XLEN-1:0] r_pc_plus4_d;
   logic            r_valid_d;

   fq_entry_t       w_head;
   logic            w_head_valid;
   logic [CW-1:0]   w_alloc_cnt;
   logic [CW-1:0]   w_unfilled_cnt;

   logic            w_req;
   logic            w_alloc;
   logic            w_kill_active;
   logic            w_fill;
   logic            w_head_ready;
   logic            w_pop;

   // ---------------------------------------------------------------------
   // Request / handshake decode
   // ---------------------------------------------------------------------
   // Reset gates the request combinationally so no fetch is offered while
   // the stage is held in reset.
   assign w_req         = i_rst_n && !PCSrcE && (w_alloc_cnt < CW'(DEPTH));
   assign w_alloc       = w_req && i_imem_gnt;
   assign w_kill_active = (r_kill_cnt != '0);
   // A response either pays off a pending kill or fills the oldest unfilled
   // entry; on a redirect it is always dropped.
   assign w_fill        = i_imem_rvalid && !w_kill_active && !PCSrcE &&
                          (w_unfilled_cnt != '0);
   assign w_head_ready  = w_head_valid && w_head.filled;
   assign w_pop         = !PCSrcE && !FlushD && !StallD && w_head_ready;

   assign o_imem_req    = w_req;
   assign o_imem_addr   = r_pc;

   // ---------------------------------------------------------------------
   // Fetch queue
   // ---------------------------------------------------------------------
   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_fetch_queue (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .alloc        (w_alloc),
      .alloc_pc     (r_pc),
      .fill         (w_fill),
      .fill_instr   (i_imem_rdata),
      .pop          (w_pop),
      .clear        (PCSrcE),
      .head         (w_head),
      .head_valid   (w_head_valid),
      .alloc_cnt    (w_alloc_cnt),
      .unfilled_cnt (w_unfilled_cnt)
   );

   // ---------------------------------------------------------------------
   // PC register
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc <= RESET_PC;
      end else if (PCSrcE) begin
         r_pc <= PCTargetE;
      end else if (w_alloc) begin
         r_pc <= pc_plus4(r_pc);
      end
   end

   // ---------------------------------------------------------------------
   // Kill counter: responses still owed by imem for discarded fetches.
   // On redirect every unfilled entry becomes a kill, less the response
   // that arrives (and is dropped) in the redirect cycle itself.
   // ---------------------------------------------------------------------
   always_comb begin
      w_kill_next = r_kill_cnt;
      if (PCSrcE) begin
         w_kill_next = r_kill_cnt + KW'(w_unfilled_cnt) - KW'(i_imem_rvalid);
      end else if (i_imem_rvalid && w_kill_active) begin
         w_kill_next = r_kill_cnt - KW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_kill_cnt <= '0;
      end else begin
         r_kill_cnt <= w_kill_next;
      end
   end

   // ---------------------------------------------------------------------
   // IF/ID register. A bubble keeps the last PC fields and only clears
   // the instruction and valid bit.
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instr_d    <= NOP_INSTR;
         r_pc_d       <= '0;
         r_pc_plus4_d <= '0;
         r_valid_d    <= 1'b0;
      end else if (PCSrcE || FlushD) begin
         r_instr_d    <= NOP_INSTR;
         r_valid_d    <= 1'b0;
      end else if (!StallD) begin
         if (w_head_ready) begin
            r_instr_d    <= w_head.instr;
            r_pc_d       <= w_head.pc;
            r_pc_plus4_d <= pc_plus4(w_head.pc);
            r_valid_d    <= 1'b1;
         end else begin
            r_instr_d    <= NOP_INSTR;
            r_valid_d    <= 1'b0;
         end
      end
   end

   assign InstrD   = r_instr_d;
   assign PCD      = r_pc_d;
   assign PCPlus4D = r_pc_plus4_d;
   assign ValidD   = r_valid_d;

   // A response with nothing outstanding means the imem protocol broke.
   a_rvalid_has_pending : assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      !(i_imem_rvalid && !w_kill_active && (w_unfilled_cnt == '0))
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_stage_q                                                |
// | Purpose  : Self-checking bench for fetch_stage_q with an imem model of    |
// |            programmable latency and a queue-based reference model.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_stage_q;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n, pcsrc, stall, flush, gnt, rvalid;
   logic [31:0] target, rdata;
   logic        o_req, valid_d;
   logic [31:0] o_addr, instr_d, pc_d, pcp4_d;

   fetch_stage_q #(
      .XLEN      (32),
      .DEPTH     (DEPTH),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .PCSrcE        (pcsrc),
      .PCTargetE     (target),
      .StallD        (stall),
      .FlushD        (flush),
      .o_imem_req    (o_req),
      .o_imem_addr   (o_addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .InstrD        (instr_d),
      .PCD           (pc_d),
      .PCPlus4D      (pcp4_d),
      .ValidD        (valid_d)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // ---------------- reference model state ----------------
   typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ment_t;
   ment_t       mq[$];
   logic [31:0] pc_m, m_instr, m_pcd, m_pcp4;
   bit          m_valid;
   int          kill_m;

   // ---------------- imem model ----------------
   typedef struct { logic [31:0] addr; int due; } imreq_t;
   imreq_t imq[$];
   int     cyc = 0;
   int     lat = 1;

   // sampled inputs/outputs of the cycle being closed by the next edge
   logic        s_rst_n, s_pcsrc, s_stall = 1'b0, s_flush, s_gnt, s_rvalid, s_req;
   logic [31:0] s_target, s_rdata, s_addr;

   // new IF/ID contents observed on the DUT (for literal checks)
   logic [31:0] seen_pc[$];
   logic [31:0] seen_p4[$];
   int          tick_no = 0;
   int          first_valid_tick = 0;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[23:0], 8'h13} ^ 32'h5A00_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      bit m_req;
      m_req = rst_n && !pcsrc && (mq.size() < DEPTH);
      chk("imem_req",  32'(o_req),   32'(m_req));
      chk("imem_addr", o_addr,       pc_m);
      chk("InstrD",    instr_d,      m_instr);
      chk("PCD",       pc_d,         m_pcd);
      chk("PCPlus4D",  pcp4_d,       m_pcp4);
      chk("ValidD",    32'(valid_d), 32'(m_valid));
      if (rst_n) begin
         tick_no++;
         if (valid_d && first_valid_tick == 0) first_valid_tick = tick_no;
      end
      // a held (stalled) slot is not a new instruction
      if (valid_d === 1'b1 && !s_stall) begin
         seen_pc.push_back(pc_d);
         seen_p4.push_back(pcp4_d);
      end
   endtask

   task automatic model_update();
      if (!s_rst_n) begin
         pc_m = 32'h0; mq.delete(); kill_m = 0;
         m_instr = NOP; m_pcd = 32'h0; m_pcp4 = 32'h0; m_valid = 0;
      end else if (s_pcsrc) begin
         int unf = 0;
         foreach (mq[i]) if (!mq[i].filled) unf++;
         kill_m = kill_m + unf - (s_rvalid ? 1 : 0);
         mq.delete();
         pc_m = s_target;
         m_instr = NOP; m_valid = 0;
      end else begin
         bit alloc;
         alloc = (mq.size() < DEPTH) && s_gnt;
         if (s_flush) begin
            m_instr = NOP; m_valid = 0;
         end else if (!s_stall) begin
            if (mq.size() > 0 && mq[0].filled) begin
               m_instr = mq[0].instr; m_pcd = mq[0].pc; m_pcp4 = mq[0].pc + 32'd4;
               m_valid = 1;
               void'(mq.pop_front());
            end else begin
               m_instr = NOP; m_valid = 0;
            end
         end
         if (s_rvalid) begin
            if (kill_m > 0) begin
               kill_m--;
            end else begin
               int idx = -1;
               foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
               if (idx >= 0) begin
                  mq[idx].instr  = s_rdata;
                  mq[idx].filled = 1;
               end else begin
                  checks++; failures++;
                  $display("FAIL model_rvalid_unexpected at %0t", $time);
               end
            end
         end
         if (alloc) begin
            mq.push_back('{pc: pc_m, instr: 32'h0, filled: 0});
            pc_m = pc_m + 32'd4;
         end
      end
   endtask

   task automatic imem_update();
      if (s_rst_n && s_req && s_gnt) imq.push_back('{addr: s_addr, due: cyc + lat});
      cyc++;
      if (imq.size() > 0 && imq[0].due <= cyc) begin
         rvalid = 1'b1;
         rdata  = imem_word(imq[0].addr);
         void'(imq.pop_front());
      end else begin
         rvalid = 1'b0;
         rdata  = 32'h0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_outputs();
      s_rst_n = rst_n; s_pcsrc = pcsrc; s_target = target; s_stall = stall;
      s_flush = flush; s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata;
      s_req = o_req; s_addr = o_addr;
      @(posedge clk);
      model_update();
      #1;
      imem_update();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0; gnt = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 1'b0;
      target = 32'h0; rvalid = 1'b0; rdata = 32'h0;
      pc_m = 32'h0; kill_m = 0; m_instr = NOP; m_pcd = 32'h0; m_pcp4 = 32'h0; m_valid = 0;

      // reset held two cycles with gnt=1
      run(2);
      chk("rst_req",    32'(o_req),   32'd0);
      chk("rst_validd", 32'(valid_d), 32'd0);
      chk("rst_instrd", instr_d,      32'h0000_0013);
      rst_n = 1'b1;
      #1;
      chk("first_addr", o_addr,       32'h0000_0000);
      chk("first_req",  32'(o_req),   32'd1);

      // streaming, 1-cycle imem
      lat = 1;
      run(10);
      chk("first_valid_tick", 32'(first_valid_tick), 32'd4);
      chk("stream_pc0", seen_pc[0], 32'h0);
      chk("stream_pc1", seen_pc[1], 32'h4);
      chk("stream_pc2", seen_pc[2], 32'h8);
      chk("stream_pc3", seen_pc[3], 32'hC);

      // backpressure
      stall = 1'b1;
      run(6);
      chk("stall_req_full", 32'(o_req), 32'd0);
      stall = 1'b0;
      run(12);
      ok = 1;
      for (int i = 1; i < seen_pc.size(); i++)
         if (seen_pc[i] !== seen_pc[i-1] + 32'd4) ok = 0;
      chk("no_skip_dup", 32'(ok), 32'd1);

      // decode flush mid-stream
      flush = 1'b1; run(1); flush = 1'b0;
      run(4);

      // irregular grants, 2-cycle imem
      lat = 2;
      for (int i = 0; i < 9; i++) begin
         gnt = (i % 3) != 0;
         tick();
      end
      gnt = 1'b1;
      run(4);

      // redirect with responses still in flight
      lat = 3;
      run(5);
      pcsrc = 1'b1; target = 32'h0000_0100;
      tick();
      pcsrc = 1'b0;
      seen_pc.delete(); seen_p4.delete();
      run(12);
      chk("redir_first_pc",  seen_pc[0], 32'h0000_0100);
      chk("redir_second_pc", seen_pc[1], 32'h0000_0104);

      // redirect in the same cycle as rvalid, with StallD high
      lat = 1;
      run(6);
      chk("pre_redir_rvalid", 32'(rvalid), 32'd1);
      stall = 1'b1; pcsrc = 1'b1; target = 32'h0000_0200;
      tick();
      pcsrc = 1'b0; stall = 1'b0;
      chk("redir_stall_validd", 32'(valid_d), 32'd0);
      chk("redir_stall_instrd", instr_d,      32'h0000_0013);
      seen_pc.delete(); seen_p4.delete();
      run(8);
      chk("redir_stall_first_pc", seen_pc[0], 32'h0000_0200);

      // redirect to the top of the address space
      pcsrc = 1'b1; target = 32'hFFFF_FFFC;
      tick();
      pcsrc = 1'b0;
      seen_pc.delete(); seen_p4.delete();
      run(8);
      chk("wrap_pc",       seen_pc[0], 32'hFFFF_FFFC);
      chk("wrap_pcplus4",  seen_p4[0], 32'h0000_0000);
      chk("wrap_next_pc",  seen_pc[1], 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
